// File: rtl/maxpool_sched.sv
// maxpool_sched: pairs incoming samples per channel and serialises each pair into SER_BW chunks for a maxpool stage.
module maxpool_sched #(
  parameter int NO_CH  = 10,
  parameter int BW_IN  = 8,
  parameter int SER_BW = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [NO_CH*BW_IN-1:0]   in_data,
  input  logic                     in_last,
  output logic                     mp_vld,
  output logic [NO_CH*SER_BW-1:0]  mp_data,
  output logic                     mp_first,
  output logic                     frame_done,
  output logic [15:0]              pair_cnt
);
  localparam int NSER = 2*BW_IN/SER_BW;
  localparam int PW   = 2*BW_IN;
  localparam int KW   = NSER > 1 ? $clog2(NSER) : 1;
  typedef enum logic [1:0] {WAIT_A, WAIT_B, SEND} state_t;
  state_t                   r_state, w_state_n;
  logic [KW-1:0]            r_k, w_k_n;
  logic [NO_CH*BW_IN-1:0]   r_a, w_a_n, r_nxt, w_nxt_n, w_e_data;
  logic                     r_nxt_vld, w_nxt_vld_n, r_nxt_last, w_nxt_last_n;
  logic [NO_CH*PW-1:0]      r_pair, w_pair_n;
  logic                     r_pair_last, w_pair_last_n;
  logic                     w_acc, w_k_last, w_nk_last, w_send_n, w_e_vld, w_e_last;
  logic [NO_CH*SER_BW-1:0]  w_chunk;
  function automatic logic [NO_CH*PW-1:0] pack(input logic [NO_CH*BW_IN-1:0] b, input logic [NO_CH*BW_IN-1:0] a);
    for (int i = 0; i < NO_CH; i++)
      pack[i*PW +: PW] = {b[i*BW_IN +: BW_IN], a[i*BW_IN +: BW_IN]};
  endfunction
  assign in_rdy    = !rst && (r_state != SEND || !r_nxt_vld);
  assign w_acc     = in_vld && in_rdy;
  assign w_k_last  = r_k == KW'(NSER-1);
  assign w_nk_last = w_k_n == KW'(NSER-1);
  assign w_send_n  = w_state_n == SEND;
  // a sample taken on the last chunk counts as the buffered next-A
  assign w_e_vld   = r_nxt_vld || w_acc;
  assign w_e_data  = r_nxt_vld ? r_nxt : in_data;
  assign w_e_last  = r_nxt_vld ? r_nxt_last : in_last;
  always_comb begin
    w_state_n     = r_state;
    w_k_n         = r_k;
    w_a_n         = r_a;
    w_nxt_n       = r_nxt;
    w_nxt_vld_n   = r_nxt_vld;
    w_nxt_last_n  = r_nxt_last;
    w_pair_n      = r_pair;
    w_pair_last_n = r_pair_last;
    case (r_state)
      WAIT_A: if (w_acc) begin
        if (in_last) begin
          w_pair_n      = pack('0, in_data);
          w_pair_last_n = 1'b1;
          w_k_n         = '0;
          w_state_n     = SEND;
        end else begin
          w_a_n     = in_data;
          w_state_n = WAIT_B;
        end
      end
      WAIT_B: if (w_acc) begin
        w_pair_n      = pack(in_data, r_a);
        w_pair_last_n = in_last;
        w_k_n         = '0;
        w_state_n     = SEND;
      end
      SEND: if (!w_k_last) begin
        w_k_n = r_k + KW'(1);
        if (w_acc) begin
          w_nxt_n      = in_data;
          w_nxt_last_n = in_last;
          w_nxt_vld_n  = 1'b1;
        end
      end else begin
        w_nxt_vld_n = 1'b0;
        w_k_n       = '0;
        if (w_e_vld && w_e_last) begin
          w_pair_n      = pack('0, w_e_data);
          w_pair_last_n = 1'b1;
        end else if (w_e_vld) begin
          w_a_n     = w_e_data;
          w_state_n = WAIT_B;
        end else
          w_state_n = WAIT_A;
      end
      default: w_state_n = WAIT_A;
    endcase
  end
  always_comb begin
    w_chunk = '0;
    for (int i = 0; i < NO_CH; i++)
      w_chunk[i*SER_BW +: SER_BW] = w_pair_n[i*PW + int'(w_k_n)*SER_BW +: SER_BW];
  end
  // outputs are computed from next state so chunk 0 shows the cycle after the completing accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= WAIT_A;
      r_k         <= '0;
      r_a         <= '0;
      r_nxt       <= '0;
      r_nxt_vld   <= 1'b0;
      r_nxt_last  <= 1'b0;
      r_pair      <= '0;
      r_pair_last <= 1'b0;
      mp_vld      <= 1'b0;
      mp_first    <= 1'b0;
      mp_data     <= '0;
      frame_done  <= 1'b0;
      pair_cnt    <= '0;
    end else begin
      r_state     <= w_state_n;
      r_k         <= w_k_n;
      r_a         <= w_a_n;
      r_nxt       <= w_nxt_n;
      r_nxt_vld   <= w_nxt_vld_n;
      r_nxt_last  <= w_nxt_last_n;
      r_pair      <= w_pair_n;
      r_pair_last <= w_pair_last_n;
      mp_vld      <= w_send_n;
      mp_first    <= w_send_n && w_k_n == '0;
      mp_data     <= w_send_n ? w_chunk : mp_data;
      frame_done  <= w_send_n && w_nk_last && w_pair_last_n;
      pair_cnt    <= pair_cnt + 16'(w_send_n && w_nk_last);
    end
  end
endmodule

// File: tb/tb_maxpool_sched.sv
// tb_maxpool_sched: directed checks on a default instance (NSER=1) and a SER_BW=8 instance (NSER=2).
module tb_maxpool_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic d_vld = 1'b0, d_last = 1'b0, d_rdy, d_mvld, d_first, d_done;
  logic [79:0] d_in = '0;
  logic [159:0] d_mp;
  logic [15:0] d_cnt;
  logic e_vld = 1'b0, e_last = 1'b0, e_rdy, e_mvld, e_first, e_done;
  logic [79:0] e_in = '0;
  logic [79:0] e_mp;
  logic [15:0] e_cnt;
  int total = 0, bad = 0;
  logic [79:0] a_v, b_v;
  logic [159:0] exp_v;
  logic [7:0] seq [20];
  logic fseq [20];
  int got, acc, gaps, n;
  logic prev_first, w;

  maxpool_sched u_d (
    .clk(clk), .rst(rst), .in_vld(d_vld), .in_rdy(d_rdy), .in_data(d_in), .in_last(d_last),
    .mp_vld(d_mvld), .mp_data(d_mp), .mp_first(d_first), .frame_done(d_done), .pair_cnt(d_cnt));
  maxpool_sched #(.NO_CH(10), .BW_IN(8), .SER_BW(8)) u_e (
    .clk(clk), .rst(rst), .in_vld(e_vld), .in_rdy(e_rdy), .in_data(e_in), .in_last(e_last),
    .mp_vld(e_mvld), .mp_data(e_mp), .mp_first(e_first), .frame_done(e_done), .pair_cnt(e_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step; step;
    chk("rst_e_rdy", e_rdy, 0);
    chk("rst_d_rdy", d_rdy, 0);
    chk("rst_e_mvld", e_mvld, 0);
    chk("rst_e_first", e_first, 0);
    chk("rst_e_mp", e_mp, 0);
    chk("rst_e_cnt", e_cnt, 0);
    chk("rst_d_cnt", d_cnt, 0);
    chk("rst_d_done", d_done, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", e_rdy, 1);
    // default pattern: A_i = 9-i, B_i = i, packed {B_i, A_i}
    for (int i = 0; i < 10; i++) begin
      a_v[i*8 +: 8] = 8'(9 - i);
      b_v[i*8 +: 8] = 8'(i);
      exp_v[i*16 +: 16] = {8'(i), 8'(9 - i)};
    end
    d_in = a_v; d_vld = 1'b1; step;
    d_in = b_v; step;
    d_vld = 1'b0;
    chk("d_pair_vld", d_mvld, 1);
    chk("d_pair_first", d_first, 1);
    chk("d_pair_data", d_mp, exp_v);
    chk("d_pair_cnt", d_cnt, 1);
    chk("d_pair_done", d_done, 0);
    step;
    chk("d_idle_vld", d_mvld, 0);
    chk("d_idle_hold", d_mp, exp_v);
    d_in = 80'hAB; d_last = 1'b1; d_vld = 1'b1; step;
    d_vld = 1'b0; d_last = 1'b0;
    chk("d_lastA_data", d_mp, 160'h00AB);
    chk("d_lastA_done", d_done, 1);
    chk("d_lastA_cnt", d_cnt, 2);
    step;
    chk("d_lastA_done_clr", d_done, 0);
    // NSER=2 basic pair
    e_in = 80'h12; e_vld = 1'b1; step;
    e_in = 80'h34; step;
    e_vld = 1'b0;
    chk("e_c0_vld", e_mvld, 1);
    chk("e_c0_first", e_first, 1);
    chk("e_c0_data", e_mp, 80'h12);
    chk("e_c0_cnt", e_cnt, 0);
    step;
    chk("e_c1_vld", e_mvld, 1);
    chk("e_c1_first", e_first, 0);
    chk("e_c1_data", e_mp, 80'h34);
    chk("e_c1_cnt", e_cnt, 1);
    chk("e_c1_done", e_done, 0);
    step;
    chk("e_idle_vld", e_mvld, 0);
    chk("e_idle_first", e_first, 0);
    chk("e_idle_hold", e_mp, 80'h34);
    // 3-sample frame: {B,A} then {0,C}
    e_vld = 1'b1; e_in = 80'h11; step;
    e_in = 80'h22; step;
    chk("f_c0_data", e_mp, 80'h11);
    chk("f_c0_first", e_first, 1);
    e_in = 80'h33; e_last = 1'b1; step;
    e_vld = 1'b0; e_last = 1'b0;
    chk("f_c1_data", e_mp, 80'h22);
    chk("f_c1_rdy", e_rdy, 0);
    chk("f_c1_done", e_done, 0);
    chk("f_c1_cnt", e_cnt, 2);
    step;
    chk("f_c2_data", e_mp, 80'h33);
    chk("f_c2_first", e_first, 1);
    chk("f_c2_vld", e_mvld, 1);
    step;
    chk("f_c3_data", e_mp, 80'h00);
    chk("f_c3_done", e_done, 1);
    chk("f_c3_cnt", e_cnt, 3);
    step;
    chk("f_done_pulse", e_done, 0);
    chk("f_end_vld", e_mvld, 0);
    // 10 back-to-back samples
    got = 0; acc = 0; gaps = 0; n = 1; prev_first = 1'b0;
    e_in = 80'(n); e_vld = 1'b1;
    for (int c = 0; c < 60; c++) begin
      w = e_vld && e_rdy;
      step;
      if (w) begin
        acc++; n++;
        if (n > 10) e_vld = 1'b0;
        else e_in = 80'(n);
      end
      if (prev_first && !e_mvld) gaps++;
      prev_first = e_mvld && e_first;
      if (e_mvld && got < 20) begin
        seq[got] = e_mp[7:0];
        fseq[got] = e_first;
        got++;
      end
    end
    chk("s_accepted", acc, 10);
    chk("s_chunks", got, 10);
    chk("s_gaps", gaps, 0);
    chk("s_cnt", e_cnt, 8);
    for (int i = 0; i < got && i < 10; i++) begin
      chk($sformatf("s_chunk%0d", i), seq[i], 8'(i + 1));
      chk($sformatf("s_first%0d", i), fseq[i], (i % 2) == 0);
    end
    // reset during chunk 0 aborts the pair
    e_vld = 1'b1; e_in = 80'h55; step;
    e_in = 80'h66; step;
    e_vld = 1'b0;
    chk("r_c0_vld", e_mvld, 1);
    chk("r_c0_data", e_mp, 80'h55);
    rst = 1'b1; step;
    chk("r_abort_vld", e_mvld, 0);
    chk("r_abort_cnt", e_cnt, 0);
    chk("r_abort_rdy", e_rdy, 0);
    rst = 1'b0;
    #1;
    chk("r_post_rdy", e_rdy, 1);
    e_vld = 1'b1; e_in = 80'h77; step;
    e_in = 80'h88; step;
    e_vld = 1'b0;
    chk("r_n0_data", e_mp, 80'h77);
    chk("r_n0_first", e_first, 1);
    step;
    chk("r_n1_data", e_mp, 80'h88);
    chk("r_n1_cnt", e_cnt, 1);
    // 65537 single-sample frames wrap the pair counter
    rst = 1'b1; step;
    rst = 1'b0;
    d_in = 80'h1; d_last = 1'b1; d_vld = 1'b1;
    repeat (65537) step;
    chk("w_cnt", d_cnt, 16'h0001);
    chk("w_done", d_done, 1);
    chk("w_vld", d_mvld, 1);
    d_vld = 1'b0; d_last = 1'b0;
    step; step;
    chk("w_idle_vld", d_mvld, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
